// File: rtl/mem_store_buffer_if.sv
// Request/memory bundle between the MEM stage, the store buffer and the data memory.
// The pipeline side drives the request and observes stall; the buffer side drives the
// data-memory port and occupancy status.
interface mem_store_buffer_if #(
  parameter int AW    = 12,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // MEM-stage request
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [1:0]    req_we;
  logic [1:0]    req_memRead;

  // pipeline hold
  logic          stall;

  // data-memory port
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;
  logic [1:0]    dm_we;
  logic [1:0]    dm_memRead;

  // occupancy
  logic          sb_empty;
  logic [CW-1:0] sb_count;

  modport master (
    output req_addr, req_wdata, req_we, req_memRead,
    input  stall, dm_addr, dm_din, dm_we, dm_memRead, sb_empty, sb_count
  );

  modport slave (
    input  req_addr, req_wdata, req_we, req_memRead,
    output stall, dm_addr, dm_din, dm_we, dm_memRead, sb_empty, sb_count
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Store buffer between the MEM stage and the 128-word data memory.
// Stores are queued oldest-first and drained one per cycle whenever the memory port
// is not taken by a load. A load that aliases any queued store (word index bits
// [8:2]) stalls and drains until no matching entry remains, so loads never see
// stale data. A store arriving while the buffer is full stalls for one cycle.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage; validity is derived from head/count so reset only touches pointers.
  logic [AW-1:0] addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [1:0]    we_mem   [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  logic [DEPTH-1:0] match;
  logic store_req, load_req, hit, full, empty, accept, drain;

  // Reserved we=11 counts as no store; a store with a load request wins over the load.
  assign store_req = (bus.req_we == 2'b01) || (bus.req_we == 2'b10);
  assign load_req  = (bus.req_memRead != 2'b00) && !store_req;
  assign full      = (count_reg == FULL_CNT);
  assign empty     = (count_reg == '0);

  // Per-entry address compare, qualified by the entry lying inside the valid window.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PW-1:0] age;
    assign age       = PW'(gi) - head_reg;
    assign match[gi] = ({1'b0, age} < count_reg) &&
                       (addr_mem[gi][8:2] == bus.req_addr[8:2]);
  end

  assign hit    = load_req && (|match);
  assign accept = store_req && !full;
  // The port drains the head unless a non-hitting load owns it.
  assign drain  = !empty && (!load_req || hit);

  assign bus.stall    = hit || (store_req && full);
  assign bus.sb_empty = empty;
  assign bus.sb_count = count_reg;

  // Memory port mux: a clean load passes through, otherwise the head entry drains.
  always_comb begin
    bus.dm_addr    = bus.req_addr;
    bus.dm_din     = '0;
    bus.dm_we      = 2'b00;
    bus.dm_memRead = 2'b00;
    if (load_req && !hit) begin
      bus.dm_memRead = bus.req_memRead;
    end else if (drain) begin
      bus.dm_addr = addr_mem[head_reg];
      bus.dm_din  = data_mem[head_reg];
      bus.dm_we   = we_mem[head_reg];
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    head_next  = head_reg + PW'(drain);
    tail_next  = tail_reg + PW'(accept);
    count_next = count_reg + CW'(accept) - CW'(drain);
  end

  // Pointer/count registers; reset empties the buffer and discards pending stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry write at the tail on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_mem[tail_reg] <= bus.req_addr;
      data_mem[tail_reg] <= bus.req_wdata;
      we_mem[tail_reg]   <= bus.req_we;
    end
  end
endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: random and directed MEM-stage traffic,
// a queue-based reference model for timing, an architectural memory for load values,
// and a monitor that checks every memory-port write and load against expectations.
module tb_mem_store_buffer;
  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_store_buffer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  mem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [1:0]    we;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    rd;
    logic [31:0]   val;
  } ld_t;

  wr_t mq[$];       // stores held by the buffer (model)
  wr_t exp_wr[$];   // expected memory writes in acceptance order
  ld_t exp_ld[$];   // expected load issues with their architectural values

  logic [31:0] gold [128];  // program-order memory image
  logic [31:0] mem  [128];  // memory as written by the DUT port

  int n_vec  = 0;
  int n_err  = 0;
  bit mon_en = 1'b0;

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] off,
                                         input logic [1:0] rd);
    logic [7:0] b;
    b = w[off*8 +: 8];
    case (rd)
      2'b01:   return w;
      2'b10:   return {{24{b[7]}}, b};
      default: return {24'h0, b};
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d,
                                           input logic [1:0] off, input logic [1:0] we);
    logic [31:0] r;
    r = w;
    if (we == 2'b01) r = d;
    else             r[off*8 +: 8] = d[7:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes expected writes/loads whenever the memory port shows activity.
  initial begin
    wr_t e;
    ld_t l;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (bus.dm_we != 2'b00) begin
          if (exp_wr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_write: got addr %h we %b expected none at %0t",
                     bus.dm_addr, bus.dm_we, $time);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(bus.dm_addr), 32'(e.addr));
            chk("wr_we",   32'(bus.dm_we),   32'(e.we));
            if (e.we == 2'b01) chk("wr_data", bus.dm_din, e.data);
            else               chk("wr_byte", 32'(bus.dm_din[7:0]), 32'(e.data[7:0]));
          end
          mem[bus.dm_addr[8:2]] = st_merge(mem[bus.dm_addr[8:2]], bus.dm_din,
                                           bus.dm_addr[1:0], bus.dm_we);
        end
        if (bus.dm_memRead != 2'b00) begin
          if (exp_ld.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_load: got addr %h rd %b expected none at %0t",
                     bus.dm_addr, bus.dm_memRead, $time);
          end else begin
            l = exp_ld.pop_front();
            chk("ld_addr", 32'(bus.dm_addr), 32'(l.addr));
            chk("ld_rd",   32'(bus.dm_memRead), 32'(l.rd));
            chk("ld_value", ld_ext(mem[bus.dm_addr[8:2]], bus.dm_addr[1:0], bus.dm_memRead),
                l.val);
          end
        end
      end
    end
  end

  // One cycle: drive the request, compare per-cycle outputs against the model at the
  // falling edge, record expectations, then advance the model.
  task automatic step(input logic [1:0] we, input logic [1:0] rd, input logic [AW-1:0] addr,
                      input logic [31:0] wd, output bit stall_o);
    bit st, ld, hit, drain, full, exp_stall;
    wr_t w;
    ld_t l;
    bus.req_we      = we;
    bus.req_memRead = rd;
    bus.req_addr    = addr;
    bus.req_wdata   = wd;
    @(negedge clk);
    st  = (we == 2'b01) || (we == 2'b10);
    ld  = (rd != 2'b00) && !st;
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].addr[8:2] == addr[8:2]) hit = 1'b1;
    hit       = hit && ld;
    full      = (mq.size() == DEPTH);
    drain     = (mq.size() > 0) && (!ld || hit);
    exp_stall = hit || (st && full);
    chk("stall",    32'(bus.stall),    32'(exp_stall));
    chk("sb_count", 32'(bus.sb_count), 32'(mq.size()));
    chk("sb_empty", 32'(bus.sb_empty), 32'(mq.size() == 0));
    chk("dm_we_active", 32'(bus.dm_we != 2'b00), 32'(drain));
    if (ld && !hit) begin
      l.addr = addr;
      l.rd   = rd;
      l.val  = ld_ext(gold[addr[8:2]], addr[1:0], rd);
      exp_ld.push_back(l);
    end
    if (st && !full) begin
      w.addr = addr;
      w.data = wd;
      w.we   = we;
      mq.push_back(w);
      exp_wr.push_back(w);
      gold[addr[8:2]] = st_merge(gold[addr[8:2]], wd, addr[1:0], we);
    end
    if (drain) void'(mq.pop_front());
    stall_o = exp_stall;
    @(posedge clk);
    #1;
  endtask

  // One instruction: re-presented unchanged while the model says the stage is held.
  task automatic issue(input logic [1:0] we, input logic [1:0] rd, input logic [AW-1:0] addr,
                       input logic [31:0] wd);
    bit s;
    int n;
    n = 0;
    do begin
      step(we, rd, addr, wd, s);
      n++;
    end while (s && n < 32);
    if (s) begin
      n_vec++; n_err++;
      $display("FAIL stall_timeout: got stall after %0d cycles expected release", n);
    end
    $display("txn we=%b rd=%b addr=%h wdata=%h cycles=%0d", we, rd, addr, wd, n);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int a;
    for (int i = 0; i < 128; i++) begin
      gold[i] = 32'(i) * 32'h9E37_79B9;
      mem[i]  = gold[i];
    end

    // Reset with a load pending: loads pass straight through an empty buffer.
    bus.req_we      = 2'b00;
    bus.req_memRead = 2'b01;
    bus.req_addr    = 12'h00C;
    bus.req_wdata   = 32'h0;
    #2;
    chk("rst_stall",      32'(bus.stall),      32'd0);
    chk("rst_dm_memRead", 32'(bus.dm_memRead), 32'd1);
    chk("rst_dm_addr",    32'(bus.dm_addr),    32'h00C);
    chk("rst_sb_count",   32'(bus.sb_count),   32'd0);
    chk("rst_sb_empty",   32'(bus.sb_empty),   32'd1);
    chk("rst_dm_we",      32'(bus.dm_we),      32'd0);
    @(negedge clk);
    bus.req_memRead = 2'b00;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    issue(2'b00, 2'b00, 12'h000, 32'h0);

    // Store then dependent load.
    issue(2'b01, 2'b00, 12'h00C, 32'hDEAD_BEEF);
    issue(2'b00, 2'b01, 12'h00C, 32'h0);

    // Store burst, a non-hitting load, another store.
    issue(2'b01, 2'b00, 12'h000, 32'h1111_1111);
    issue(2'b01, 2'b00, 12'h004, 32'h2222_2222);
    issue(2'b01, 2'b00, 12'h008, 32'h3333_3333);
    issue(2'b01, 2'b00, 12'h010, 32'h4444_4444);
    issue(2'b00, 2'b01, 12'h040, 32'h0);
    issue(2'b01, 2'b00, 12'h014, 32'h5555_5555);
    issue(2'b00, 2'b00, 12'h000, 32'h0);

    // Byte stores followed by an unsigned byte load of the second one.
    issue(2'b10, 2'b00, 12'h021, 32'h0000_00AA);
    issue(2'b10, 2'b00, 12'h022, 32'h0000_00BB);
    issue(2'b00, 2'b11, 12'h022, 32'h0);

    // Load to a different word passes; then idle drains.
    issue(2'b01, 2'b00, 12'h100, 32'hCAFE_0100);
    issue(2'b00, 2'b01, 12'h104, 32'h0);
    issue(2'b00, 2'b00, 12'h000, 32'h0);

    // Aliased word index.
    issue(2'b01, 2'b00, 12'h204, 32'hA11A_5ED0);
    issue(2'b00, 2'b01, 12'h004, 32'h0);

    // Random traffic over a small, heavily aliased address pool.
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 9));
      a = int'($urandom_range(0, 7)) * 512 + int'($urandom_range(0, 7)) * 4;
      if (k <= 2)      issue(2'b01, 2'b00, AW'(a), $urandom);
      else if (k <= 4) issue(2'b10, 2'b00, AW'(a + int'($urandom_range(0, 3))), $urandom);
      else if (k <= 6) issue(2'b00, 2'b01, AW'(a), 32'h0);
      else if (k == 7) issue(2'b00, 2'b10, AW'(a + int'($urandom_range(0, 3))), 32'h0);
      else if (k == 8) issue(2'b00, 2'b11, AW'(a + int'($urandom_range(0, 3))), 32'h0);
      else             issue(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 2'b00, AW'(a), 32'h0);
    end

    // Let everything drain, then every expectation must have been consumed.
    repeat (DEPTH + 2) issue(2'b00, 2'b00, 12'h000, 32'h0);
    chk("exp_wr_left", 32'(exp_wr.size()), 32'd0);
    chk("exp_ld_left", 32'(exp_ld.size()), 32'd0);

    // Reset during a drain: pending store discarded, nothing written afterwards.
    issue(2'b01, 2'b00, 12'h030, 32'h1234_5678);
    bus.req_we = 2'b00;
    #1;
    chk("pre_rst_dm_we", 32'(bus.dm_we), 32'd1);
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("midrst_sb_count", 32'(bus.sb_count), 32'd0);
    chk("midrst_sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("midrst_dm_we",    32'(bus.dm_we),    32'd0);
    chk("midrst_stall",    32'(bus.stall),    32'd0);
    mq.delete();
    exp_wr.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) issue(2'b00, 2'b00, 12'h030, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
